meas_report_sequencer: RTL
==========================

MEAS_REPORT_SEQUENCER -- requirements
Module: meas_report_sequencer

Interface
REQ-001 Parameter N_CH, default 2, number of 32-bit result registers read per frame (1..8).
REQ-002 Parameter RESULT_BASE, default 32'h9, address of result register 0; channel k at RESULT_BASE+k.
REQ-003 Parameter BAUD_WORD, default 32'h0096feb5, value written to baud register 0x4 once after reset.
REQ-004 Parameter DELAY_CYC, default 100, idle cycles between frames (>=1).
REQ-005 Parameter CONTINUOUS, default 1; 1 = free-running frames, 0 = one frame per start_i pulse.
REQ-006 Parameter MAX_RETRY, default 3, reissues allowed per bus transfer on rty_i.
REQ-007 Parameter TIMEOUT_CYC, default 255, cycles allowed for ack/err/rty, and per poll loop, before abort.
REQ-008 clk_i  in  1  single clock; all logic on rising edge.
REQ-009 rst_i  in  1  synchronous, active-high reset.
REQ-010 start_i  in  1  frame request pulse; used only when CONTINUOUS=0.
REQ-011 addr_o, dat_o  out  32  Wishbone master address, write data.
REQ-012 dat_i  in  32  Wishbone read data.
REQ-013 we_o, cyc_o, stb_o, lock_o  out  1  Wishbone controls; lock_o tied 0.
REQ-014 sel_o  out  4  byte select.
REQ-015 ack_i, err_i, rty_i  in  1  Wishbone terminations.
REQ-016 state_o  out  4  current state encoding.
REQ-017 result_o  out  32  last captured channel-0 value.
REQ-018 frame_done_o  out  1  one-cycle pulse after last UART byte of a frame.
REQ-019 err_o  out  1  sticky fault flag.

Function
REQ-020 Every bus access: cyc_o=stb_o=1, addr/dat/we/sel held stable until first cycle with ack_i, err_i or rty_i; deassert cyc_o/stb_o the following cycle; dat_i sampled on ack_i.
REQ-021 Priority on simultaneous terminations: err_i > rty_i > ack_i.
REQ-022 rty_i: drop stb/cyc one cycle, reissue identical access; MAX_RETRY+1th rty_i -> FAULT.
REQ-023 No termination within TIMEOUT_CYC cycles of stb_o rise -> FAULT; err_i -> FAULT.
REQ-024 States, in order: INIT_BAUD (write BAUD_WORD to 0x4, sel 4'hF, only after reset) -> WAIT_START -> CNT_RST (write 0x01 to 0x8, sel 4'h1) -> CNT_START (write 0x80 to 0x8) -> POLL_DONE (read 0x8 until dat_i[6]=1) -> READ_CH (read N_CH registers into internal buffer) -> TX_LOAD -> TX_GO -> TX_BUSY -> TX_READY -> DELAY -> WAIT_START.
REQ-025 WAIT_START: CONTINUOUS=1 passes immediately; CONTINUOUS=0 waits for start_i=1; start_i outside WAIT_START ignored.
REQ-026 TX_LOAD writes buffer word k to 0x7 with dat_o = full word, sel_o one-hot byte b (b=0 first, LSB), k ascending; 4*N_CH bytes per frame.
REQ-027 TX_GO writes 0x80 to 0x3, sel 4'h1; TX_BUSY polls 0x5 until dat_i[4]=0; TX_READY polls 0x5 until dat_i[4]=1; then next byte or, after last, DELAY.
REQ-028 Each poll loop bounded: TIMEOUT_CYC cycles without exit condition -> FAULT.
REQ-029 DELAY: counter counts DELAY_CYC cycles, bus idle (cyc/stb/we=0, sel=0, addr/dat=0); frame_done_o pulses on DELAY entry.
REQ-030 result_o updates on ack of channel-0 read only.
REQ-031 FAULT: bus idle, err_o=1, remains until rst_i; state_o = 4'hF.
REQ-032 Byte/channel counters sized $clog2(4*N_CH)+1; no wrap inside a frame; reset to 0 at each CNT_RST.

Reset
REQ-033 rst_i=1 on any edge, including mid-transfer: next cycle cyc_o=stb_o=we_o=0, sel_o=0, addr_o=dat_o=0, result_o=0, err_o=0, frame_done_o=0, buffer cleared, state INIT_BAUD (state_o=0).
REQ-034 First access after rst_i falls is INIT_BAUD write; no partial transfer resumed.

Verification
REQ-035 Reset release, slave acks in 1 cycle -> write 0x4/0x0096feb5, then 0x8/0x01, 0x8/0x80 in order.
REQ-036 N_CH=2, results 32'h61626364, 32'h65666768 -> UART writes sel 1,2,4,8 twice, bytes 64,63,62,61,68,67,66,65; frame_done_o one pulse; result_o=32'h61626364.
REQ-037 rty_i on CNT_START twice, then ack -> three identical 0x8/0x80 accesses, err_o=0; four rty_i -> FAULT, err_o=1.
REQ-038 Counter never sets dat_i[6] -> FAULT after TIMEOUT_CYC, bus idle, err_o stays 1 until rst_i.
REQ-039 CONTINUOUS=0 -> no CNT_RST until start_i pulse; start_i during TX ignored; rst_i during TX_LOAD -> cyc_o=0 next cycle, restart at INIT_BAUD.

Source files
------------

// File: rtl/meas_report_sequencer.sv
// meas_report_sequencer
// Wishbone master that runs a measurement/report cycle: programs the UART baud
// divisor once after reset, then per frame resets and starts a counter block,
// polls it for completion, reads N_CH 32-bit results into a local buffer and
// streams every byte of that buffer out through the UART (LSB first), then idles
// DELAY_CYC cycles before the next frame.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               frame request (only when CONTINUOUS=0)
//   addr_o, dat_o, dat_i  Wishbone address / write data / read data
//   we_o, cyc_o, stb_o    Wishbone controls; lock_o tied low
//   sel_o                 byte select
//   ack_i, err_i, rty_i   Wishbone terminations (err > rty > ack)
//   state_o               current state encoding (table below)
//   result_o              last captured channel-0 value
//   frame_done_o          one-cycle pulse on entry to DELAY
//   err_o                 sticky fault flag, cleared only by rst_i
//
// state       | code | meaning
// INIT_BAUD   | 0    | write BAUD_WORD to 0x4 (once after reset)
// WAIT_START  | 1    | wait for start_i (or pass when CONTINUOUS=1)
// CNT_RST     | 2    | write 0x01 to 0x8, clear frame counters
// CNT_START   | 3    | write 0x80 to 0x8
// POLL_DONE   | 4    | read 0x8 until bit 6 set
// READ_CH     | 5    | read RESULT_BASE+k for k = 0..N_CH-1
// TX_LOAD     | 6    | write buffer word to 0x7, one-hot byte select
// TX_GO       | 7    | write 0x80 to 0x3
// TX_BUSY     | 8    | read 0x5 until bit 4 clear
// TX_READY    | 9    | read 0x5 until bit 4 set
// DELAY       | A    | bus idle for DELAY_CYC cycles
// FAULT       | F    | bus idle, err_o high until reset

module meas_report_sequencer #(
  parameter int          N_CH        = 2,
  parameter logic [31:0] RESULT_BASE = 32'h9,
  parameter logic [31:0] BAUD_WORD   = 32'h0096feb5,
  parameter int          DELAY_CYC   = 100,
  parameter int          CONTINUOUS  = 1,
  parameter int          MAX_RETRY   = 3,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [31:0] addr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        lock_o,
  output logic [3:0]  sel_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i,
  output logic [3:0]  state_o,
  output logic [31:0] result_o,
  output logic        frame_done_o,
  output logic        err_o
);

  localparam int NB = 4 * N_CH;
  localparam int CW = $clog2(NB) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int DW = $clog2(DELAY_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    S_INIT_BAUD  = 4'h0,
    S_WAIT_START = 4'h1,
    S_CNT_RST    = 4'h2,
    S_CNT_START  = 4'h3,
    S_POLL_DONE  = 4'h4,
    S_READ_CH    = 4'h5,
    S_TX_LOAD    = 4'h6,
    S_TX_GO      = 4'h7,
    S_TX_BUSY    = 4'h8,
    S_TX_READY   = 4'h9,
    S_DELAY      = 4'hA,
    S_FAULT      = 4'hF
  } state_t;

  state_t          state_q, state_d;
  // busy_q high = access on the bus; every access is preceded by one idle cycle,
  // which also gives the mandatory drop after a termination or retry.
  logic            busy_q, busy_d;
  logic [TW-1:0]   tmo_q;
  logic [TW-1:0]   poll_q;
  logic [DW-1:0]   dly_q;
  logic [RW-1:0]   retry_q;
  logic [CW-1:0]   ch_q;
  logic [CW-1:0]   byte_q;
  logic [31:0]     data_buf [N_CH];
  logic [31:0]     result_q;
  logic            frame_done_q;

  logic            t_err, t_rty, t_ack;
  logic            poll_state, poll_exit, fault;
  logic [31:0]     tx_word;

  assign t_err = busy_q & err_i;
  assign t_rty = busy_q & ~err_i & rty_i;
  assign t_ack = busy_q & ~err_i & ~rty_i & ack_i;

  assign poll_state = (state_q == S_POLL_DONE) || (state_q == S_TX_BUSY) ||
                      (state_q == S_TX_READY);
  assign poll_exit  = t_ack & (((state_q == S_POLL_DONE) &  dat_i[6]) ||
                               ((state_q == S_TX_BUSY)   & ~dat_i[4]) ||
                               ((state_q == S_TX_READY)  &  dat_i[4]));

  always_comb begin
    tx_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if ((byte_q >> 2) == CW'(k)) tx_word = data_buf[k];
    end
  end

  // Bus outputs decode straight from state; they cannot move while busy_q is
  // high because state and indices only change on a termination.
  always_comb begin
    addr_o = '0;
    dat_o  = '0;
    we_o   = 1'b0;
    sel_o  = '0;
    if (busy_q) begin
      case (state_q)
        S_INIT_BAUD: begin addr_o = 32'h4; dat_o = BAUD_WORD; we_o = 1'b1; sel_o = 4'hF; end
        S_CNT_RST:   begin addr_o = 32'h8; dat_o = 32'h01;    we_o = 1'b1; sel_o = 4'h1; end
        S_CNT_START: begin addr_o = 32'h8; dat_o = 32'h80;    we_o = 1'b1; sel_o = 4'h1; end
        S_POLL_DONE: begin addr_o = 32'h8; sel_o = 4'hF; end
        S_READ_CH:   begin addr_o = RESULT_BASE + 32'(ch_q); sel_o = 4'hF; end
        S_TX_LOAD:   begin addr_o = 32'h7; dat_o = tx_word;   we_o = 1'b1;
                           sel_o = 4'b0001 << byte_q[1:0]; end
        S_TX_GO:     begin addr_o = 32'h3; dat_o = 32'h80;    we_o = 1'b1; sel_o = 4'h1; end
        S_TX_BUSY,
        S_TX_READY:  begin addr_o = 32'h5; sel_o = 4'hF; end
        default: ;
      endcase
    end
  end

  assign cyc_o        = busy_q;
  assign stb_o        = busy_q;
  assign lock_o       = 1'b0;
  assign state_o      = state_q;
  assign result_o     = result_q;
  assign frame_done_o = frame_done_q;
  assign err_o        = (state_q == S_FAULT);

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    fault   = 1'b0;
    case (state_q)
      S_WAIT_START: if (CONTINUOUS != 0 || start_i) state_d = S_CNT_RST;
      S_DELAY:      if (dly_q == '0) state_d = S_WAIT_START;
      S_FAULT:      ;
      default: begin
        if (!busy_q) begin
          busy_d = 1'b1;
        end else if (t_err) begin
          fault = 1'b1;
        end else if (t_rty) begin
          if (retry_q == RW'(MAX_RETRY)) fault = 1'b1;
          else busy_d = 1'b0;
        end else if (t_ack) begin
          busy_d = 1'b0;
          case (state_q)
            S_INIT_BAUD: state_d = S_WAIT_START;
            S_CNT_RST:   state_d = S_CNT_START;
            S_CNT_START: state_d = S_POLL_DONE;
            S_POLL_DONE: if (dat_i[6]) state_d = S_READ_CH;
            S_READ_CH:   if (ch_q == CW'(N_CH - 1)) state_d = S_TX_LOAD;
            S_TX_LOAD:   state_d = S_TX_GO;
            S_TX_GO:     state_d = S_TX_BUSY;
            S_TX_BUSY:   if (!dat_i[4]) state_d = S_TX_READY;
            S_TX_READY:  if (dat_i[4])
                           state_d = (byte_q == CW'(NB - 1)) ? S_DELAY : S_TX_LOAD;
            default: ;
          endcase
        end else if (tmo_q == '0) begin
          fault = 1'b1;
        end
      end
    endcase
    if (poll_state && poll_q == '0 && !poll_exit) fault = 1'b1;
    if (fault) begin
      state_d = S_FAULT;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_INIT_BAUD;
      busy_q       <= 1'b0;
      tmo_q        <= '0;
      poll_q       <= '0;
      dly_q        <= '0;
      retry_q      <= '0;
      ch_q         <= '0;
      byte_q       <= '0;
      result_q     <= '0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < N_CH; k++) data_buf[k] <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= (state_d == S_DELAY) && (state_q != S_DELAY);

      // Access timeout counts from the first cycle stb_o is high.
      if (!busy_q) tmo_q <= TW'(TIMEOUT_CYC - 1);
      else if (tmo_q != '0) tmo_q <= tmo_q - 1'b1;

      // Poll-loop timeout spans all retries of one poll state.
      if (state_d != state_q) poll_q <= TW'(TIMEOUT_CYC - 1);
      else if (poll_q != '0) poll_q <= poll_q - 1'b1;

      if (state_d == S_DELAY && state_q != S_DELAY) dly_q <= DW'(DELAY_CYC - 1);
      else if (state_q == S_DELAY && dly_q != '0) dly_q <= dly_q - 1'b1;

      if (t_ack) retry_q <= '0;
      else if (t_rty && retry_q != RW'(MAX_RETRY)) retry_q <= retry_q + 1'b1;

      if (state_q == S_CNT_RST) begin
        ch_q   <= '0;
        byte_q <= '0;
      end

      if (state_q == S_READ_CH && t_ack) begin
        for (int k = 0; k < N_CH; k++) begin
          if (ch_q == CW'(k)) data_buf[k] <= dat_i;
        end
        if (ch_q == '0) result_q <= dat_i;
        if (ch_q != CW'(N_CH - 1)) ch_q <= ch_q + 1'b1;
      end

      if (state_q == S_TX_READY && poll_exit && byte_q != CW'(NB - 1))
        byte_q <= byte_q + 1'b1;
    end
  end

endmodule
